// File: rtl/imu_frame_buffer_if.sv
// Word-write stream from the IMU reader plus the host read/pop port.
// The master side drives writes and host requests; the buffer is the slave.
interface imu_frame_buffer_if;
   logic [7:0]  in_addr;
   logic        in_wr;
   logic [31:0] in_d;
   logic        in_irq;
   logic [4:0]  host_addr;
   logic [31:0] host_q;
   logic        host_pop;

   modport master (
      output in_addr, in_wr, in_d, in_irq, host_addr, host_pop,
      input  host_q
   );

   modport slave (
      input  in_addr, in_wr, in_d, in_irq, host_addr, host_pop,
      output host_q
   );
endinterface

// File: rtl/imu_frame_buffer.sv
// Circular buffer of IMU sample frames: assembles 17-word frames into slots,
// commits complete ones with a sequence tag and serves the oldest to the host.
module imu_frame_buffer #(
   parameter int NUM_FRAMES  = 4,
   parameter int FRAME_WORDS = 17,
   parameter int BASE_ADDR   = 4
) (
   input  logic                          c,
   input  logic                          rst_n,
   imu_frame_buffer_if.slave             bus,
   output logic [$clog2(NUM_FRAMES)-1:0] frame_cnt,
   output logic                          frame_irq,
   output logic [15:0]                   drop_cnt,
   output logic [15:0]                   err_cnt
);

   localparam int AW = $clog2(NUM_FRAMES);
   localparam int MW = AW + 5;

   typedef enum logic {
      ST_EMPTY,
      ST_FILL
   } fill_state_t;

   fill_state_t state_reg, state_next;

   logic [AW-1:0]          head_reg, head_next;
   logic [AW-1:0]          tail_reg, tail_next;
   logic [FRAME_WORDS-1:0] mask_reg, mask_next;
   logic [15:0]            seq_reg, seq_next;
   logic [15:0]            drop_cnt_reg, drop_cnt_next;
   logic [15:0]            err_cnt_reg, err_cnt_next;
   logic                   frame_irq_reg, frame_irq_next;
   logic [31:0]            host_q_reg;

   logic [31:0] mem [NUM_FRAMES*32];
   logic [15:0] seq_mem [NUM_FRAMES];

   logic [8:0]             addr_ext;
   logic [8:0]             addr_off;
   logic                   in_range;
   logic                   wr_en;
   logic [4:0]             word_idx;
   logic [FRAME_WORDS-1:0] wr_bit;
   logic [FRAME_WORDS-1:0] mask_merged;
   logic                   commit;
   logic                   discard;
   logic                   pop_ok;
   logic                   full;
   logic [MW-1:0]          wr_idx;
   logic [MW-1:0]          rd_idx;

   // Address decode: widen by one bit so the subtraction cannot wrap.
   assign addr_ext = {1'b0, bus.in_addr};
   assign addr_off = addr_ext - 9'(BASE_ADDR);
   assign in_range = (addr_ext >= 9'(BASE_ADDR)) && (addr_off < 9'(FRAME_WORDS));
   assign word_idx = addr_off[4:0];
   assign wr_en    = bus.in_wr && in_range;

   genvar gi;
   generate
      for (gi = 0; gi < FRAME_WORDS; gi++) begin : g_wr_bit
         assign wr_bit[gi] = wr_en && (word_idx == 5'(gi));
      end
   endgenerate

   // A write in the same cycle as in_irq counts toward completeness.
   assign mask_merged = mask_reg | wr_bit;

   assign frame_cnt = head_reg - tail_reg;
   assign full      = (frame_cnt == AW'(NUM_FRAMES - 1));
   assign pop_ok    = bus.host_pop && (frame_cnt != '0);
   assign wr_idx    = {head_reg, word_idx};
   assign rd_idx    = {tail_reg, bus.host_addr};

   always_comb begin
      state_next = state_reg;
      mask_next  = mask_merged;
      commit     = 1'b0;
      discard    = 1'b0;
      case (state_reg)
         ST_EMPTY: begin
            if (bus.in_irq) begin
               commit     = &mask_merged;
               discard    = ~(&mask_merged);
               mask_next  = '0;
               state_next = ST_EMPTY;
            end else if (wr_en) begin
               state_next = ST_FILL;
            end
         end
         ST_FILL: begin
            if (bus.in_irq) begin
               commit     = &mask_merged;
               discard    = ~(&mask_merged);
               mask_next  = '0;
               state_next = ST_EMPTY;
            end
         end
         default: begin
            mask_next  = '0;
            state_next = ST_EMPTY;
         end
      endcase
   end

   always_comb begin
      head_next      = head_reg;
      tail_next      = tail_reg;
      drop_cnt_next  = drop_cnt_reg;
      err_cnt_next   = err_cnt_reg;
      seq_next       = seq_reg;
      frame_irq_next = commit;

      if (commit) begin
         head_next = head_reg + AW'(1);
      end
      // Eviction on overflow and a host pop both retire the tail slot once.
      if (pop_ok || (commit && full)) begin
         tail_next = tail_reg + AW'(1);
      end
      if (commit && full && !pop_ok && (drop_cnt_reg != 16'hFFFF)) begin
         drop_cnt_next = drop_cnt_reg + 16'd1;
      end
      if (discard && (err_cnt_reg != 16'hFFFF)) begin
         err_cnt_next = err_cnt_reg + 16'd1;
      end
      if (bus.in_irq) begin
         seq_next = seq_reg + 16'd1;
      end
   end

   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_EMPTY;
         head_reg      <= '0;
         tail_reg      <= '0;
         mask_reg      <= '0;
         seq_reg       <= '0;
         drop_cnt_reg  <= '0;
         err_cnt_reg   <= '0;
         frame_irq_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         head_reg      <= head_next;
         tail_reg      <= tail_next;
         mask_reg      <= mask_next;
         seq_reg       <= seq_next;
         drop_cnt_reg  <= drop_cnt_next;
         err_cnt_reg   <= err_cnt_next;
         frame_irq_reg <= frame_irq_next;
      end
   end

   // Sequence tags live beside the data RAM so a commit never needs a
   // second RAM write port in the same cycle as the final data word.
   always_ff @(posedge c) begin
      if (wr_en) begin
         mem[wr_idx] <= bus.in_d;
      end
      if (commit) begin
         seq_mem[head_reg] <= seq_reg;
      end
   end

   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         host_q_reg <= '0;
      end else if (frame_cnt == '0) begin
         host_q_reg <= '0;
      end else if (bus.host_addr == 5'd31) begin
         host_q_reg <= {16'h0000, seq_mem[tail_reg]};
      end else if (bus.host_addr < 5'(FRAME_WORDS)) begin
         host_q_reg <= mem[rd_idx];
      end else begin
         host_q_reg <= '0;
      end
   end

   assign bus.host_q = host_q_reg;
   assign frame_irq  = frame_irq_reg;
   assign drop_cnt   = drop_cnt_reg;
   assign err_cnt    = err_cnt_reg;

endmodule
